// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_port_arbiter_pkg
// Purpose  : Shared widths, FSM encodings and helpers for the SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;
    localparam int PHYS_MASK_W     = 29;
    localparam int STARVE_CNT_W    = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_IWAIT = 2'b01,
        ARB_DWAIT = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'b00,
        GRANT_FETCH = 2'b01,
        GRANT_DATA  = 2'b10
    } arb_grant_t;

    // Virtual-to-physical mapping: the top segment bits are simply cleared.
    function automatic logic [INST_ADDR_BUS_W-1:0] phys_addr(
        input logic [PHYS_MASK_W-1:0] vaddr
    );
        return {{(INST_ADDR_BUS_W-PHYS_MASK_W){1'b0}}, vaddr};
    endfunction

endpackage : sram_port_arbiter_pkg
`default_nettype wire

// File: rtl/sram_port_arbiter_starve_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : arb_starve_cnt
// Purpose  : Saturating count of data grants made while a fetch is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_cnt
    import sram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_grant,
    input  logic i_grant,
    input  logic i_pending,
    output logic limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_grant || !i_pending) begin
            r_count <= '0;
        end else if (d_grant && (r_count < LIMIT_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign limit = (r_count >= LIMIT_C);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one synchronous SRAM port between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DSTARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       i_req,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       i_ack,
    output logic                       i_rvalid,
    output logic [REG_BUS_W-1:0]       i_rdata,

    input  logic                       d_req,
    input  logic [3:0]                 d_wen,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic [REG_BUS_W-1:0]       d_wdata,
    output logic                       d_ack,
    output logic                       d_rvalid,
    output logic [REG_BUS_W-1:0]       d_rdata,

    output logic                       stallreq_if,
    output logic                       stallreq_mem,

    output logic                       sram_en,
    output logic [3:0]                 sram_wen,
    output logic [INST_ADDR_BUS_W-1:0] sram_addr,
    output logic [REG_BUS_W-1:0]       sram_wdata,
    input  logic [REG_BUS_W-1:0]       sram_rdata
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    arb_grant_t           w_grant;
    logic                 w_starve_limit;
    logic                 w_d_is_read;
    logic [REG_BUS_W-1:0] r_i_rdata_hold;
    logic [REG_BUS_W-1:0] r_d_rdata_hold;

    assign w_d_is_read = (d_wen == 4'b0000);

    if (ADDR_W > PHYS_MASK_W) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{i_addr[ADDR_W-1:PHYS_MASK_W], d_addr[ADDR_W-1:PHYS_MASK_W]};
    end

    // Data wins unless fetch has already been passed over LIMIT times.
    // Nothing is issued while reset is held so every output reads as zero.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!rst) begin
            if (d_req && (!i_req || !w_starve_limit)) begin
                w_grant = GRANT_DATA;
            end else if (i_req) begin
                w_grant = GRANT_FETCH;
            end
        end
    end

    arb_starve_cnt #(
        .LIMIT (DSTARVE_MAX)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .d_grant   (w_grant == GRANT_DATA),
        .i_grant   (w_grant == GRANT_FETCH),
        .i_pending (i_req),
        .limit     (w_starve_limit)
    );

    always_comb begin
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        case (w_grant)
            GRANT_FETCH: begin
                i_ack     = 1'b1;
                sram_en   = 1'b1;
                sram_addr = phys_addr(i_addr[PHYS_MASK_W-1:0]);
            end
            GRANT_DATA: begin
                d_ack      = 1'b1;
                sram_en    = 1'b1;
                sram_wen   = d_wen;
                sram_addr  = phys_addr(d_addr[PHYS_MASK_W-1:0]);
                sram_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The wait state only marks which requester owns the data returning now;
    // a fresh issue in the same cycle decides where the FSM goes next.
    always_comb begin
        w_state_nxt = ARB_IDLE;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;
        case (r_state)
            ARB_IWAIT: i_rvalid = 1'b1;
            ARB_DWAIT: d_rvalid = 1'b1;
            default:   ;
        endcase
        if (w_grant == GRANT_FETCH) begin
            w_state_nxt = ARB_IWAIT;
        end else if ((w_grant == GRANT_DATA) && w_d_is_read) begin
            w_state_nxt = ARB_DWAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_rdata_hold <= '0;
            r_d_rdata_hold <= '0;
        end else begin
            if (i_rvalid) begin
                r_i_rdata_hold <= sram_rdata;
            end
            if (d_rvalid) begin
                r_d_rdata_hold <= sram_rdata;
            end
        end
    end

    assign i_rdata = i_rvalid ? sram_rdata : r_i_rdata_hold;
    assign d_rdata = d_rvalid ? sram_rdata : r_d_rdata_hold;

    assign stallreq_if  = i_req & ~i_ack & ~rst;
    assign stallreq_mem = ~rst & ((d_req & ~d_ack) | ((r_state == ARB_DWAIT) & ~d_rvalid));

    a_dwait_returns: assert property (@(posedge clk) disable iff (rst)
        !((r_state == ARB_DWAIT) && !d_rvalid));

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed scoreboard bench for sram_port_arbiter with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DSTARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [3:0]  d_wen = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_rvalid;
    logic [31:0] d_rdata;
    logic        stallreq_if, stallreq_mem;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;

    sram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DSTARVE_MAX (DSTARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_wen        (d_wen),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten SRAM words read back as the bitwise inverse of their address.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : ~sram_addr;
            end else begin : b_wr
                logic [31:0] w;
                w = mem.exists(sram_addr) ? mem[sram_addr] : ~sram_addr;
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr] = w;
            end
        end
    end

    a_i_hold: assert property (@(posedge clk) disable iff (rst) (i_req && !i_ack) |=> i_req);
    a_d_hold: assert property (@(posedge clk) disable iff (rst) (d_req && !d_ack) |=> d_req);

    int          checks = 0;
    int          errors = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic        prev_iread = 1'b0;
    logic        prev_dread = 1'b0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data whenever the DUT presents rvalid.
    always @(negedge clk) begin
        if (rst) begin
            last_i = '0;
            last_d = '0;
        end else begin
            if (i_rvalid) begin
                if (iq.size() == 0) chk("i_rvalid_spurious", {31'b0, i_rvalid}, 32'h0);
                else begin
                    last_i = iq.pop_front();
                    chk("i_rdata", i_rdata, last_i);
                end
            end else begin
                chk("i_rdata_hold", i_rdata, last_i);
            end
            if (d_rvalid) begin
                if (dq.size() == 0) chk("d_rvalid_spurious", {31'b0, d_rvalid}, 32'h0);
                else begin
                    last_d = dq.pop_front();
                    chk("d_rdata", d_rdata, last_d);
                end
            end else begin
                chk("d_rdata_hold", d_rdata, last_d);
            end
        end
    end

    // Called at posedge+1: drive one cycle, check the issue side, push expectations.
    task automatic step(input string tag,
                        input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] wd,
                        input logic exp_iack, input logic exp_dack,
                        input logic [31:0] exp_addr,
                        input logic [31:0] exp_i, input logic [31:0] exp_d);
        i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = wd;
        #3;
        chk({tag, ":i_ack"},        {31'b0, i_ack},        {31'b0, exp_iack});
        chk({tag, ":d_ack"},        {31'b0, d_ack},        {31'b0, exp_dack});
        chk({tag, ":stallreq_if"},  {31'b0, stallreq_if},  {31'b0, ir & ~exp_iack});
        chk({tag, ":stallreq_mem"}, {31'b0, stallreq_mem}, {31'b0, dr & ~exp_dack});
        chk({tag, ":i_rvalid"},     {31'b0, i_rvalid},     {31'b0, prev_iread});
        chk({tag, ":d_rvalid"},     {31'b0, d_rvalid},     {31'b0, prev_dread});
        chk({tag, ":sram_en"},      {31'b0, sram_en},      {31'b0, exp_iack | exp_dack});
        chk({tag, ":sram_wen"},     {28'b0, sram_wen},     {28'b0, (exp_dack ? dw : 4'b0000)});
        chk({tag, ":sram_addr"},    sram_addr,             exp_addr);
        if (exp_dack && (dw != 4'b0000)) chk({tag, ":sram_wdata"}, sram_wdata, wd);
        prev_iread = exp_iack;
        prev_dread = exp_dack && (dw == 4'b0000);
        if (prev_iread) iq.push_back(exp_i);
        if (prev_dread) dq.push_back(exp_d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a fetch already requesting
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        #3;
        chk("rst:i_ack",       {31'b0, i_ack},       32'h0);
        chk("rst:stallreq_if", {31'b0, stallreq_if}, 32'h0);
        chk("rst:sram_en",     {31'b0, sram_en},     32'h0);
        chk("rst:sram_addr",   sram_addr,            32'h0);
        chk("rst:i_rvalid",    {31'b0, i_rvalid},    32'h0);
        chk("rst:i_rdata",     i_rdata,              32'h0);
        chk("rst:d_rdata",     d_rdata,              32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous fetch, one rvalid per cycle
        step("t1a", 1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_0000, 32'hE03F_FFFF, 32'h0);
        step("t1b", 1'b1, 32'hBFC0_0004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_0004, 32'hE03F_FFFB, 32'h0);
        step("t1c", 1'b1, 32'hBFC0_0008, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_0008, 32'hE03F_FFF7, 32'h0);
        step("t1d", 1'b1, 32'hBFC0_000C, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_000C, 32'hE03F_FFF3, 32'h0);

        // Simultaneous requests: data first, fetch the next cycle
        step("t2a", 1'b1, 32'hBFC0_0010, 1'b1, 4'h0, 32'h8000_1000, 32'h0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 32'hFFFF_EFFF);
        step("t2b", 1'b1, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_0010, 32'hE03F_FFEF, 32'h0);

        // Partial store, then read it back
        step("t3w", 1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_2000, 32'h1234_ABCD, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 32'h0);
        step("t3r", 1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_2000, 32'h0, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 32'hFFFF_ABCD);
        idle("t3idle");

        // Starvation guard: four data grants then one fetch, repeating
        for (int c = 0; c < 11; c++) begin
            logic ea;
            ea = (c == 4) || (c == 9);
            step($sformatf("t4c%0d", c), (c < 10), 32'hBFC0_0100, 1'b1, 4'h0, 32'h8000_1000, 32'h0,
                 ea, !ea, (ea ? 32'h1FC0_0100 : 32'h0000_1000), 32'hE03F_FEFF, 32'hFFFF_EFFF);
        end

        // Back-to-back load then fetch: d_rvalid alongside i_ack
        step("t6d", 1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_3000, 32'h0, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'hFFFF_CFFF);
        step("t6i", 1'b1, 32'hBFC0_0200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1FC0_0200, 32'hE03F_FDFF, 32'h0);
        idle("t6idle");

        // Asynchronous reset while a fetch read is outstanding
        i_req = 1'b1; i_addr = 32'hBFC0_0300;
        #3;
        chk("t5:i_ack", {31'b0, i_ack}, 32'h1);
        @(posedge clk);
        #1;
        chk("t5:i_rvalid_before_rst", {31'b0, i_rvalid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t5:i_rvalid",     {31'b0, i_rvalid},     32'h0);
        chk("t5:i_ack",        {31'b0, i_ack},        32'h0);
        chk("t5:stallreq_if",  {31'b0, stallreq_if},  32'h0);
        chk("t5:sram_en",      {31'b0, sram_en},      32'h0);
        chk("t5:sram_addr",    sram_addr,             32'h0);
        chk("t5:i_rdata",      i_rdata,               32'h0);
        chk("t5:d_rdata",      d_rdata,               32'h0);
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_iread = 1'b0;
        prev_dread = 1'b0;
        idle("t5idle0");
        idle("t5idle1");

        chk("iq_drained", iq.size(), 32'h0);
        chk("dq_drained", dq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
